// File: rtl/jtag_master.sv
// JTAG initiator: turns LSB-first TMS/TDI shift commands into pad-level
// TCK/TMS/TDI/TRSTn waveforms and returns the captured TDO bits.
module jtag_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN+1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [LEN_W-1:0]   cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_tms_i,
  input  logic [MAX_LEN-1:0] cmd_tdi_i,
  input  logic               cmd_trst_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MAX_LEN-1:0] rsp_tdo_o,
  output logic               jtag_tck_o,
  output logic               jtag_tms_o,
  output logic               jtag_tdi_o,
  output logic               jtag_trst_no,
  input  logic               jtag_tdo_i
);

  localparam int unsigned CW = $clog2(2*CLK_DIV);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV-1);
  localparam logic [CW-1:0] FULL_END = CW'(2*CLK_DIV-1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [MAX_LEN-1:0] BIT0  = MAX_LEN'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    TRST,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [MAX_LEN-1:0] tms_q, tms_d;
  logic [MAX_LEN-1:0] tdi_q, tdi_d;
  logic [MAX_LEN-1:0] tdo_q, tdo_d;
  logic [MAX_LEN-1:0] bit_q, bit_d;
  logic               tck_q, tck_d;
  logic               tms_pin_q, tms_pin_d;
  logic               tdi_pin_q, tdi_pin_d;
  logic               trst_n_q, trst_n_d;
  logic               tdo_s1_q, tdo_s2_q;
  logic [LEN_W-1:0]   cmd_len_c;
  logic               last_bit;

  assign cmd_len_c = (cmd_len_i > LEN_MAX) ? LEN_MAX : cmd_len_i;
  // len_q=0 also ends here, giving TRST its single-bit minimum
  assign last_bit  = (idx_q + LEN_ONE) >= len_q;

  assign cmd_ready_o  = (state_q == IDLE);
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_tdo_o    = tdo_q;
  assign jtag_tck_o   = tck_q;
  assign jtag_tms_o   = tms_pin_q;
  assign jtag_tdi_o   = tdi_pin_q;
  assign jtag_trst_no = trst_n_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    idx_d     = idx_q;
    tms_d     = tms_q;
    tdi_d     = tdi_q;
    tdo_d     = tdo_q;
    bit_d     = bit_q;
    tck_d     = 1'b0;
    tms_pin_d = tms_pin_q;
    tdi_pin_d = tdi_pin_q;
    trst_n_d  = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          len_d = cmd_len_c;
          tms_d = cmd_tms_i;
          tdi_d = cmd_tdi_i;
          tdo_d = '0;
          bit_d = BIT0;
          idx_d = '0;
          cnt_d = '0;
          if (cmd_trst_i) begin
            state_d  = TRST;
            trst_n_d = 1'b0;
          end else if (cmd_len_c == '0) begin
            state_d = RESP;
          end else begin
            state_d   = LOW;
            tms_pin_d = cmd_tms_i[0];
            tdi_pin_d = cmd_tdi_i[0];
          end
        end
      end
      LOW: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          tck_d   = 1'b1;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        tck_d = 1'b1;
        if (cnt_q == HALF_END) begin
          // one clk before the falling edge: TDO is still stable here
          cnt_d = '0;
          tck_d = 1'b0;
          tdo_d = tdo_q | (bit_q & {MAX_LEN{tdo_s2_q}});
          if (last_bit) begin
            state_d = RESP;
          end else begin
            state_d   = LOW;
            idx_d     = idx_q + LEN_ONE;
            bit_d     = bit_q << 1;
            tms_d     = tms_q >> 1;
            tdi_d     = tdi_q >> 1;
            tms_pin_d = tms_d[0];
            tdi_pin_d = tdi_d[0];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      TRST: begin
        trst_n_d = 1'b0;
        if (cnt_q == FULL_END) begin
          cnt_d = '0;
          if (last_bit) begin
            state_d  = RESP;
            trst_n_d = 1'b1;
          end else begin
            idx_d = idx_q + LEN_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      tms_q     <= '0;
      tdi_q     <= '0;
      tdo_q     <= '0;
      bit_q     <= '0;
      tck_q     <= 1'b0;
      tms_pin_q <= 1'b1;
      tdi_pin_q <= 1'b0;
      trst_n_q  <= 1'b1;
      tdo_s1_q  <= 1'b0;
      tdo_s2_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
      tdo_q     <= tdo_d;
      bit_q     <= bit_d;
      tck_q     <= tck_d;
      tms_pin_q <= tms_pin_d;
      tdi_pin_q <= tdi_pin_d;
      trst_n_q  <= trst_n_d;
      tdo_s1_q  <= jtag_tdo_i;
      tdo_s2_q  <= tdo_s1_q;
    end
  end

endmodule

// File: doc/jtag_master.md
Name: jtag_master

Overview:
- Synthesizable JTAG initiator. It is the driving end of the JTAG interface that the SoC pad frame exposes: it generates TCK, TMS, TDI and TRSTn, and samples TDO.
- Used as an on-chip or FPGA debug bridge, and as a board-side JTAG driver for bring-up.
- Command/response valid-ready streams carry up to MAX_LEN bits per shift, LSB first.
- Runs entirely in the system clock domain; TCK is derived by a counter, not by a clock mux.

Parameters:
- CLK_DIV, 4, clk_i cycles per TCK half-period (legal >= 2).
- MAX_LEN, 32, maximum bits per command; sets the TMS/TDI/TDO vector width.
- LEN_W, $clog2(MAX_LEN+1), width of the length field (derived, do not override).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready
- cmd_len_i  in  LEN_W  bit count, 0..MAX_LEN
- cmd_tms_i  in  MAX_LEN  TMS bits, bit i applies to TCK cycle i
- cmd_tdi_i  in  MAX_LEN  TDI bits, bit i applies to TCK cycle i
- cmd_trst_i  in  1  1 = TRST pulse command instead of a shift
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_tdo_o  out  MAX_LEN  captured TDO, bit i from TCK cycle i
- jtag_tck_o  out  1  TCK to pad
- jtag_tms_o  out  1  TMS to pad
- jtag_tdi_o  out  1  TDI to pad
- jtag_trst_no  out  1  TRSTn to pad, active-low
- jtag_tdo_i  in  1  TDO from pad (asynchronous)

Behaviour:
- Clocking and reset:
  - Single clock clk_i; reset rst_i is synchronous and active-high.
  - Reset values: cmd_ready_o=1, rsp_valid_o=0, rsp_tdo_o=0, jtag_tck_o=0, jtag_tms_o=1, jtag_tdi_o=0, jtag_trst_no=1. State returns to IDLE and all counters clear.
- TDO synchroniser:
  - jtag_tdo_i passes through a 2-flop synchroniser, reset value 0.
  - The synchronised value is used for all sampling.
- FSM states: IDLE, LOW, HIGH, TRST, RESP.
- IDLE:
  - cmd_ready_o=1; it is 0 in every other state.
  - On cmd_valid_i & cmd_ready_o, latch len, tms, tdi and trst, clear the TDO shift register, and clear the bit index i.
  - Next state:
    - TRST if trst=1;
    - else RESP if len=0;
    - else LOW.
- LOW, CLK_DIV cycles:
  - jtag_tck_o=0.
  - jtag_tms_o and jtag_tdi_o are driven with bit i from the first LOW cycle of that bit.
  - Then go to HIGH.
- HIGH, CLK_DIV cycles:
  - jtag_tck_o=1.
  - In the last HIGH cycle, capture the synchronised TDO into shift-register bit i.
  - Then go to RESP if i=len-1; otherwise increment i and go to LOW.
- Per-bit and total timing:
  - Each bit takes exactly 2*CLK_DIV clocks; TCK duty cycle is 50%.
  - TDO is captured at the TCK falling edge minus one clk_i. The target updates TDO on the falling edge, so this samples the stable value.
- TRST:
  - jtag_trst_no=0 and jtag_tck_o=0 for max(len,1)*2*CLK_DIV cycles.
  - TMS and TDI hold their previous values.
  - Then jtag_trst_no=1 and go to RESP with rsp_tdo_o=0.
- RESP:
  - rsp_valid_o=1, and rsp_tdo_o is held stable until rsp_ready_i.
  - Bits at index >= len are 0.
  - On handshake: rsp_valid_o=0 and go to IDLE; the next command can be accepted the following cycle.
- Latency, from the command handshake cycle to the first rsp_valid_o cycle:
  - shift command: 1 + len*2*CLK_DIV;
  - len=0 shift: 1;
  - TRST: 1 + max(len,1)*2*CLK_DIV.
- Idle pin levels:
  - After a command, TMS and TDI hold the last driven values; TCK stays 0 in IDLE and RESP.
- Illegal length:
  - cmd_len_i > MAX_LEN is clamped to MAX_LEN.
- Reset mid-operation:
  - rst_i high in any state forces reset values on the next edge.
  - Any in-flight command or pending response is discarded.
  - TCK drops to 0 without completing the half-period.

Test Plan:
1. Reset/idle: assert rst_i 3 cycles, then release -> cmd_ready_o=1, rsp_valid_o=0, tck=0, tms=1, tdi=0, trst_no=1.
2. TAP reset sequence: len=5, tms=0x1F, tdi=0 -> exactly 5 TCK rising edges, 8 clk apart, tms=1 throughout; rsp_valid_o first high 41 cycles after the handshake; rsp_tdo_o=0 with TDO tied low.
3. TDO capture: len=32, tdi=0x12345678; bench TAP model changes TDO on each TCK falling edge to bit k of 0xDEADBEEF -> rsp_tdo_o=0xDEADBEEF, and TDI observed at each rising edge equals 0x12345678 LSB first.
4. Partial length and backpressure: len=8, TDO tied 1, rsp_ready_i held low 10 cycles -> rsp_tdo_o=0x000000FF stable, cmd_ready_o=0 throughout; a back-to-back command is accepted the cycle after the response handshake.
5. TRST and len=0: trst=1, len=3 -> trst_no low for exactly 24 cycles with no TCK edge, then response 0. Next, len=0 shift -> rsp_valid_o one cycle after accept, no TCK edge.
6. Reset mid-shift: assert rst_i during bit 10 of a len=32 command while in HIGH -> next cycle tck=0, tms=1, no response ever issued; a fresh command afterwards completes correctly.
